// File: rtl/dma_bus_arbiter.sv
// ============================================================================
// Module   : dma_bus_arbiter
// Purpose  : Hands the bus from the 8088 CPU to one of four DMA channels for a
//            single-mode transfer, then gives it back to the CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_bus_arbiter #(
    parameter int HOLD_SETTLE = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] dma_request,
    input  logic [3:0] channel_mask,
    input  logic       rotate_priority,
    input  logic       cpu_bus_idle,
    input  logic       processor_lock_n,
    input  logic       transfer_done,
    output logic [3:0] dma_acknowledge_n,
    output logic       address_enable_n,
    output logic       dma_wait_n,
    output logic [1:0] active_channel,
    output logic       timeout_pulse
);

    localparam int c_settle_w  = $clog2(HOLD_SETTLE + 1);
    localparam int c_timeout_w = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                 state_q,      state_d;
    logic [c_settle_w-1:0]  settle_cnt_q, settle_cnt_d;
    logic [c_timeout_w-1:0] grant_cnt_q,  grant_cnt_d;
    logic [1:0]             ptr_q,        ptr_d;
    logic [1:0]             channel_q,    channel_d;
    logic                   timeout_q,    timeout_d;

    logic [3:0] w_req;
    logic [1:0] w_winner;

    assign w_req = dma_request & ~channel_mask;

    function automatic logic [1:0] pick_fixed(input logic [3:0] req);
        logic [1:0] win;
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win = 2'(i);
        end
        return win;
    endfunction

    // Scan upward from the pointer, wrapping 3 -> 0; first set bit wins.
    function automatic logic [1:0] pick_rotating(input logic [3:0] req,
                                                 input logic [1:0] ptr);
        logic [1:0] win;
        logic [1:0] idx;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        w_winner = rotate_priority ? pick_rotating(w_req, ptr_q) : pick_fixed(w_req);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            grant_cnt_q  <= '0;
            ptr_q        <= 2'd0;
            channel_q    <= 2'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            grant_cnt_q  <= grant_cnt_d;
            ptr_q        <= ptr_d;
            channel_q    <= channel_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        grant_cnt_d  = grant_cnt_q;
        ptr_d        = ptr_q;
        channel_d    = channel_q;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req != 4'b0000) state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (w_req == 4'b0000) begin
                    state_d = ST_IDLE;
                end else if (cpu_bus_idle && processor_lock_n) begin
                    channel_d    = w_winner;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Winner is already latched, so request changes here are moot.
                if (settle_cnt_q == c_settle_w'(HOLD_SETTLE - 1)) begin
                    state_d     = ST_GRANT;
                    grant_cnt_d = '0;
                    if (rotate_priority) ptr_d = channel_q + 2'd1;
                end else begin
                    settle_cnt_d = settle_cnt_q + c_settle_w'(1);
                end
            end
            ST_GRANT: begin
                if (transfer_done) begin
                    state_d = ST_RELEASE;
                end else if (grant_cnt_q == c_timeout_w'(TIMEOUT - 1)) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    grant_cnt_d = grant_cnt_q + c_timeout_w'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state so reset clears them without a clock.
    always_comb begin
        dma_acknowledge_n = 4'b1111;
        address_enable_n  = 1'b1;
        dma_wait_n        = 1'b1;
        case (state_q)
            ST_REQUEST: begin
                dma_wait_n = 1'b0;
            end
            ST_SETTLE, ST_RELEASE: begin
                address_enable_n = 1'b0;
                dma_wait_n       = 1'b0;
            end
            ST_GRANT: begin
                dma_acknowledge_n = ~(4'b0001 << channel_q);
                address_enable_n  = 1'b0;
                dma_wait_n        = 1'b0;
            end
            default: begin
                dma_acknowledge_n = 4'b1111;
            end
        endcase
    end

    assign active_channel = channel_q;
    assign timeout_pulse  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
// ============================================================================
// Module   : tb_dma_bus_arbiter
// Purpose  : Directed vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_bus_arbiter;

    logic       clock;
    logic       reset_n;
    logic [3:0] dma_request;
    logic [3:0] channel_mask;
    logic       rotate_priority;
    logic       cpu_bus_idle;
    logic       processor_lock_n;
    logic       transfer_done;
    logic [3:0] dma_acknowledge_n;
    logic       address_enable_n;
    logic       dma_wait_n;
    logic [1:0] active_channel;
    logic       timeout_pulse;

    int n_cmp = 0;
    int n_err = 0;

    dma_bus_arbiter #(.HOLD_SETTLE(2), .TIMEOUT(64)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .dma_request       (dma_request),
        .channel_mask      (channel_mask),
        .rotate_priority   (rotate_priority),
        .cpu_bus_idle      (cpu_bus_idle),
        .processor_lock_n  (processor_lock_n),
        .transfer_done     (transfer_done),
        .dma_acknowledge_n (dma_acknowledge_n),
        .address_enable_n  (address_enable_n),
        .dma_wait_n        (dma_wait_n),
        .active_channel    (active_channel),
        .timeout_pulse     (timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [3:0] mask;
        logic       rot;
        logic       idle;
        logic       lock_n;
        logic       done;
        logic [3:0] dack;
        logic       aen;
        logic       wait_n;
        logic [1:0] ch;
        logic       to;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] dack, input logic aen,
                             input logic wait_n, input logic [1:0] ch, input logic to);
        cmp({name, ".dack"}, {4'b0, dma_acknowledge_n}, {4'b0, dack});
        cmp({name, ".aen"},  {7'b0, address_enable_n},  {7'b0, aen});
        cmp({name, ".wait"}, {7'b0, dma_wait_n},        {7'b0, wait_n});
        cmp({name, ".ch"},   {6'b0, active_channel},    {6'b0, ch});
        cmp({name, ".to"},   {7'b0, timeout_pulse},     {7'b0, to});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    // Waits for any DACK; reports cycles spent, or FAIL if the bound expires.
    task automatic wait_grant(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cycles++;
            if (dma_acknowledge_n != 4'b1111) break;
        end
        n_cmp++;
        if (dma_acknowledge_n == 4'b1111) begin
            n_err++;
            $display("FAIL %s: no grant within %0d cycles", name, cycles);
        end
    endtask

    task automatic pulse_done();
        transfer_done = 1'b1;
        tick();
        transfer_done = 1'b0;
    endtask

    task automatic grant_series(input logic rot, input logic [1:0] e0,
                                input logic [1:0] e1, input logic [1:0] e2);
        logic [1:0] exp_ch[3];
        int cyc;
        exp_ch[0] = e0; exp_ch[1] = e1; exp_ch[2] = e2;
        rotate_priority = rot;
        dma_request     = 4'b1011;
        for (int g = 0; g < 3; g++) begin
            wait_grant($sformatf("prio%0d_g%0d", rot, g), cyc);
            cmp($sformatf("prio%0d_g%0d.lat", rot, g), 8'(cyc), (g == 0) ? 8'd4 : 8'd5);
            cmp($sformatf("prio%0d_g%0d.ch", rot, g), {6'b0, active_channel}, {6'b0, exp_ch[g]});
            cmp($sformatf("prio%0d_g%0d.dack", rot, g), {4'b0, dma_acknowledge_n},
                {4'b0, ~(4'b0001 << exp_ch[g])});
            pulse_done();
        end
        dma_request = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        int cyc;
        int gcyc;

        //          name      req      mask     rot  idle lock done  dack     aen  wt   ch    to
        vecs[0]  = '{"req",   4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{"set1",  4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[2]  = '{"set2",  4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[3]  = '{"grant", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[4]  = '{"drqlo", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{"done",  4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[6]  = '{"idle",  4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{"ddone", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{"mask1", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{"mask2", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[10] = '{"wreq",  4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[11] = '{"wdrop", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[12] = '{"busy1", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[13] = '{"busy2", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[14] = '{"bdrop", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0};

        reset_n          = 1'b0;
        dma_request      = 4'b0000;
        channel_mask     = 4'b0000;
        rotate_priority  = 1'b0;
        cpu_bus_idle     = 1'b1;
        processor_lock_n = 1'b1;
        transfer_done    = 1'b0;
        #12;
        reset_n = 1'b1;
        check_all("reset", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            dma_request      = vecs[i].req;
            channel_mask     = vecs[i].mask;
            rotate_priority  = vecs[i].rot;
            cpu_bus_idle     = vecs[i].idle;
            processor_lock_n = vecs[i].lock_n;
            transfer_done    = vecs[i].done;
            tick();
            check_all(vecs[i].name, vecs[i].dack, vecs[i].aen, vecs[i].wait_n,
                      vecs[i].ch, vecs[i].to);
        end
        transfer_done = 1'b0;
        cpu_bus_idle  = 1'b1;

        // Fixed vs rotating priority with back-to-back requests held.
        do_reset();
        grant_series(1'b0, 2'd0, 2'd0, 2'd0);
        do_reset();
        grant_series(1'b1, 2'd0, 2'd1, 2'd3);

        // Lock hold-off: REQUEST persists while locked, SETTLE one edge after release.
        do_reset();
        rotate_priority  = 1'b0;
        processor_lock_n = 1'b0;
        dma_request      = 4'b0001;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all($sformatf("lock%0d", i), 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        end
        processor_lock_n = 1'b1;
        tick();
        check_all("unlock", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);

        // Timeout: no done, GRANT lasts TIMEOUT cycles, then one-cycle pulse.
        wait_grant("to_grant", cyc);
        dma_request = 4'b0000;
        gcyc = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (dma_acknowledge_n == 4'b1111) break;
            gcyc++;
        end
        cmp("to_len", 8'(gcyc), 8'd64);
        check_all("to_rel", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
        tick();
        check_all("to_idle", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);

        // Reset mid-GRANT after the rotating pointer has moved to 2.
        rotate_priority = 1'b1;
        dma_request     = 4'b0010;
        wait_grant("rst_grant", cyc);
        cmp("rst_pre.dack", {4'b0, dma_acknowledge_n}, 8'h0d);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("rst_async", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        #2;
        reset_n     = 1'b1;
        dma_request = 4'b1011;
        wait_grant("rst_after", cyc);
        cmp("rst_after.ch", {6'b0, active_channel}, 8'd0);
        cmp("rst_after.lat", 8'(cyc), 8'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Sequences bus ownership between the 8088 CPU and the four 8237-style DMA request lines in the KFPC-XT chipset. Requests CPU hold, waits for a safe bus boundary, then disables CPU address drivers via address_enable_n. Grants exactly one channel per single-mode transfer and returns the bus to the CPU. Outputs feed the bus arbiter and ready logic: dma_acknowledge_n, address_enable_n and dma_wait_n.

## Interface
- HOLD_SETTLE, 2: cycles address_enable_n is low before DACK asserts (≥1)
- TIMEOUT, 64: max cycles in GRANT awaiting transfer_done (≥2)
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- dma_request  in  4  DREQ level per channel, active-high
- channel_mask  in  4  1 = channel ignored
- rotate_priority  in  1  0 = fixed (ch0 highest), 1 = rotating
- cpu_bus_idle  in  1  CPU at passive status / T4 boundary
- processor_lock_n  in  1  low = CPU locked, hold not allowed
- transfer_done  in  1  one-cycle pulse, DMA cycle complete
- dma_acknowledge_n  out  4  DACK per channel, active-low, one-hot-low
- address_enable_n  out  1  low while DMA owns bus
- dma_wait_n  out  1  low while hold requested/held
- active_channel  out  2  latched winner index
- timeout_pulse  out  1  one-cycle pulse on forced release

## Operation
- Effective request: req = dma_request & ~channel_mask.
- States: IDLE, REQUEST, SETTLE, GRANT, RELEASE. Moore outputs decoded from registered state.
- IDLE: all outputs inactive (DACK 4'b1111, AEN 1, wait_n 1). When req ≠ 0, go to REQUEST.
- REQUEST: dma_wait_n = 0.
  - req == 0: return to IDLE (request withdrawn, no grant).
  - Else if cpu_bus_idle = 1 and processor_lock_n = 1: latch the winner into active_channel and go to SETTLE.
  - Else: stay.
- Winner selection:
  - Fixed mode: lowest index set in req.
  - Rotating mode: scan from pointer upward, wrapping 3→0.
  - The pointer resets to 0. It updates to (winner+1) mod 4 on entry to GRANT, in rotating mode only.
- SETTLE: AEN = 0, wait_n = 0. A counter counts HOLD_SETTLE cycles, then the block goes to GRANT. Request changes are ignored because the winner is already latched.
- GRANT: DACK[active_channel] = 0, AEN = 0, wait_n = 0.
  - transfer_done = 1: go to RELEASE.
  - TIMEOUT cycles elapse without done: go to RELEASE and pulse timeout_pulse for 1 cycle.
  - The DREQ of the winner dropping does not end the grant.
- RELEASE: DACK all high, AEN = 0, wait_n = 0 for 1 cycle, then go to IDLE. AEN goes high on entry to IDLE.
- IDLE lasts at least 1 cycle between grants, which guarantees the CPU one bus window.
- transfer_done outside GRANT is ignored.
- active_channel holds its last value outside a grant; reset value 0.
- Async reset in any state: IDLE, counters 0, pointer 0, every output at its inactive/zero value immediately. No partial DACK.

## Timing
- A request asserted before edge E0 causes REQUEST from E0. dma_wait_n goes low after E0.
- Bus-idle condition sampled true at edge E1 → SETTLE. AEN goes low after E1.
- GRANT at E1+HOLD_SETTLE. DACK goes low after that edge.
- Minimum latency from request to DACK: 2+HOLD_SETTLE edges.
- transfer_done sampled high at edge Ed: DACK high after Ed, AEN high after Ed+1.
- Back-to-back requests: the next DACK comes no earlier than Ed+1+(2+HOLD_SETTLE)… measured from IDLE.
- Timeout: the GRANT cycle counter starts at 0 on entry. Forced release happens at the edge where the count reaches TIMEOUT−1. timeout_pulse is high during the first RELEASE cycle.

## Test plan
- Single request, fixed mode, HOLD_SETTLE=2:
  - Stimulus: dma_request=4'b0100, cpu_bus_idle=1, lock_n=1.
  - Response: wait_n low at cycle 1, AEN low at cycle 2, DACK=4'b1011 at cycle 4, active_channel=2.
  - Then: done pulse → DACK 1111 next cycle, AEN 1 one cycle later.
- Fixed vs rotating priority:
  - Stimulus: req=4'b1011 held across three grants.
  - Fixed response: grants ch0, ch0, ch0.
  - Rotating response: grants ch0, ch1, ch3.
- Lock/busy hold-off:
  - Stimulus: lock_n=0 for 10 cycles with req pending.
  - Response: state stays REQUEST with AEN=1 and DACK=1111. Release lock → SETTLE on the next edge.
- Withdrawal and masking:
  - Withdrawal: req drops during REQUEST → IDLE, wait_n high, no DACK.
  - Masking: channel_mask=4'b0001 with dma_request=4'b0001 → stays IDLE.
- Timeout: TIMEOUT=64 with no transfer_done → DACK high after 64 GRANT cycles, timeout_pulse one cycle, IDLE after.
- Reset mid-GRANT: reset_n low asynchronously → DACK=1111, AEN=1, wait_n=1 with no clock edge. Arbitration restarts from pointer 0.
